// File: rtl/result_ascii_conv.sv
// Binary to fixed-width ASCII decimal converter using shift-and-add-3 (double dabble).
// One bit per cycle, then a formatting cycle with optional leading-zero blanking.
module result_ascii_conv #(
    parameter int WIDTH    = 24,
    parameter int DIGITS   = 8,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic [8*DIGITS-1:0]   ascii_flat,
    output logic [1:0]            state_dbg
);

    // Handshake: start is a request sampled only while busy=0; a request
    // seen while busy=1 is dropped. done pulses for one cycle and ascii_flat
    // is valid from that cycle until the next done pulse.

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    function automatic logic [8*DIGITS-1:0] reset_string();
        logic [8*DIGITS-1:0] s;
        s = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (BLANK_LZ != 0 && i != 0) s[8*i +: 8] = 8'h20;
            else                         s[8*i +: 8] = 8'h30;
        end
        return s;
    endfunction

    localparam logic [8*DIGITS-1:0] ASCII_RST = reset_string();

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_FMT   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0]      shift_reg;
    logic [4*DIGITS-1:0]   bcd;
    logic [4*DIGITS-1:0]   bcd_adj;
    logic [CW-1:0]         bit_cnt;
    logic [8*DIGITS-1:0]   fmt_str;
    logic                  busy_d;
    logic                  done_d;

    assign state_dbg = state;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_SHIFT;
            S_SHIFT: if (bit_cnt == LAST_BIT) state_nx = S_FMT;
            S_FMT:   state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Output decode, registered below so no input reaches an output combinationally
    always_comb begin
        busy_d = (state_nx != S_IDLE);
        done_d = (state_nx == S_DONE);
    end

    // Add 3 to every nibble of 5 or more before the shift so it carries correctly
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Walk from the most significant digit down; blank until the first nonzero digit
    always_comb begin
        logic       seen_nz;
        logic [3:0] nib;
        fmt_str = '0;
        seen_nz = 1'b0;
        nib     = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib = bcd[4*i +: 4];
            if (nib != 4'd0 || i == 0) seen_nz = 1'b1;
            if (BLANK_LZ != 0 && !seen_nz) fmt_str[8*i +: 8] = 8'h20;
            else                           fmt_str[8*i +: 8] = 8'h30 + {4'h0, nib};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg  <= '0;
            bcd        <= '0;
            bit_cnt    <= '0;
            ascii_flat <= ASCII_RST;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            busy <= busy_d;
            done <= done_d;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        shift_reg <= value;
                        bcd       <= '0;
                        bit_cnt   <= '0;
                    end
                end
                S_SHIFT: begin
                    bcd       <= {bcd_adj[4*DIGITS-2:0], shift_reg[WIDTH-1]};
                    shift_reg <= shift_reg << 1;
                    bit_cnt   <= bit_cnt + CW'(1);
                end
                // Load at the end of FMT so the string is already valid while done is high
                S_FMT:   ascii_flat <= fmt_str;
                default: ;
            endcase
        end
    end

endmodule
